// File: rtl/add_sub_pipe_if.sv
// add_sub_pipe_if: handshake and data bundle for add_sub_pipe.
//   master : drives in_valid, a, b, cin, sub, out_ready; observes the rest
//   slave  : the pipeline side (accepts operations, presents results)
//   WIDTH must match the WIDTH of the attached add_sub_pipe.
interface add_sub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined two's-complement adder/subtractor.
//   WIDTH-bit operation split into STAGES chunks of CW = WIDTH/STAGES bits.
//   Stage k resolves chunk k; the carry and the not-yet-used operand bits
//   travel forward with the partial sum. A final register rank holds the
//   result and the cout/ovf/zero flags.
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous active-low reset
//   bus   add_sub_pipe_if.slave (in_valid/in_ready, a, b, cin, sub,
//         out_valid/out_ready, sum, cout, ovf, zero)
// Latency is STAGES edges counted from the accepting edge's cycle; the
// whole pipe shifts together when adv = !out_valid || out_ready.
module add_sub_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  add_sub_pipe_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic             in_ready_int;
  logic             out_vld_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [WIDTH-1:0] sum_q;

  assign adv          = !out_vld_q || bus.out_ready;
  assign in_ready_int = adv && rst_n;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits from chunk k upward; lower chunks are already resolved.
    localparam int OPW = WIDTH - k * CW;

    logic [OPW-1:0]        a_i;
    logic [OPW-1:0]        bp_i;
    logic                  c_i;
    logic                  v_i;
    logic [CW:0]           chunk;
    logic [(k+1)*CW-1:0]   sum_n;

    assign chunk = {1'b0, a_i[CW-1:0]} + {1'b0, bp_i[CW-1:0]} + {{CW{1'b0}}, c_i};

    if (k == 0) begin : g_first
      // Subtract is a + ~b + 1 with the borrow folded into the carry-in.
      assign a_i   = bus.a;
      assign bp_i  = bus.sub ? ~bus.b : bus.b;
      assign c_i   = bus.sub ? ~bus.cin : bus.cin;
      assign v_i   = bus.in_valid && in_ready_int;
      assign sum_n = chunk[CW-1:0];
    end else begin : g_next
      logic [OPW-1:0]    a_q;
      logic [OPW-1:0]    bp_q;
      logic [k*CW-1:0]   lo_q;
      logic              c_q;
      logic              vld_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q   <= '0;
          bp_q  <= '0;
          lo_q  <= '0;
          c_q   <= 1'b0;
          vld_q <= 1'b0;
        end else if (adv) begin
          a_q   <= g_stage[k-1].a_i[OPW+CW-1:CW];
          bp_q  <= g_stage[k-1].bp_i[OPW+CW-1:CW];
          lo_q  <= g_stage[k-1].sum_n;
          c_q   <= g_stage[k-1].chunk[CW];
          vld_q <= g_stage[k-1].v_i;
        end
      end

      assign a_i   = a_q;
      assign bp_i  = bp_q;
      assign c_i   = c_q;
      assign v_i   = vld_q;
      assign sum_n = {chunk[CW-1:0], lo_q};
    end
  end

  logic [WIDTH-1:0] last_sum;
  logic             last_a_msb;
  logic             last_bp_msb;
  logic             last_c;
  logic             last_v;

  assign last_sum    = g_stage[STAGES-1].sum_n;
  assign last_a_msb  = g_stage[STAGES-1].a_i[CW-1];
  assign last_bp_msb = g_stage[STAGES-1].bp_i[CW-1];
  assign last_c      = g_stage[STAGES-1].chunk[CW];
  assign last_v      = g_stage[STAGES-1].v_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else if (adv) begin
      out_vld_q <= last_v;
      sum_q     <= last_sum;
      cout_q    <= last_c;
      ovf_q     <= (last_a_msb == last_bp_msb) && (last_sum[WIDTH-1] != last_a_msb);
      zero_q    <= (last_sum == '0);
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_vld_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
module tb_add_sub_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_sub_pipe_if #(.WIDTH(8))  bus8();
  add_sub_pipe_if #(.WIDTH(32)) bus32();

  add_sub_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  add_sub_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  int n_err    = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: {zero, ovf, cout, sum[31:0]} for a w-bit operation.
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [32:0] full;
    logic [31:0] m, bb, s, am;
    logic        c, v;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am   = a & m;
    bb   = (sub ? ~b : b) & m;
    full = {1'b0, am} + {1'b0, bb} + {32'd0, (sub ? ~cin : cin)};
    s    = full[31:0] & m;
    c    = full[w];
    v    = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
    return {(s == 32'd0), v, c, s};
  endfunction

  task automatic op8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] e_sum, input logic e_cout,
                     input logic e_ovf, input logic e_zero);
    bus8.in_valid  = 1'b1;
    bus8.sub       = s;
    bus8.a         = a;
    bus8.b         = b;
    bus8.cin       = c;
    bus8.out_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, bus8.in_ready, 1'b1);
    tick;
    bus8.in_valid = 1'b0;
    #1;
    check({tag, "_early"}, bus8.out_valid, 1'b0);
    tick;
    check({tag, "_vld"},  bus8.out_valid, 1'b1);
    check({tag, "_sum"},  bus8.sum, e_sum);
    check({tag, "_cout"}, bus8.cout, e_cout);
    check({tag, "_ovf"},  bus8.ovf, e_ovf);
    check({tag, "_zero"}, bus8.zero, e_zero);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [34:0] exp_q[$];
  logic [34:0] e;
  logic [34:0] snap;
  logic [7:0]  ca, cb;
  logic        cc, cs;
  int          sent, got;
  logic [31:0] va[4];
  logic [31:0] vb[4];
  logic        vc[4];
  logic        vs[4];

  initial begin
    rst_n           = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.cin        = 1'b0;
    bus8.sub        = 1'b0;
    bus8.out_ready  = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.cin       = 1'b0;
    bus32.sub       = 1'b0;
    bus32.out_ready = 1'b1;

    tick;
    tick;
    check("rst_vld",   bus8.out_valid, 1'b0);
    check("rst_sum",   bus8.sum, 8'h00);
    check("rst_cout",  bus8.cout, 1'b0);
    check("rst_ovf",   bus8.ovf, 1'b0);
    check("rst_zero",  bus8.zero, 1'b0);
    check("rst_rdy",   bus8.in_ready, 1'b0);
    check("rst_vld32", bus32.out_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst", bus8.in_ready, 1'b1);

    op8("add_0f_01", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    op8("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    op8("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    op8("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
    op8("sub_10_0f", 1'b1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

    // Drain, then stream 10 mixed operations with a 3-cycle stall.
    bus8.in_valid = 1'b0;
    tick;
    tick;
    check("drain", bus8.out_valid, 1'b0);
    sent = 0;
    got  = 0;
    ca = 8'($urandom_range(0, 255));
    cb = 8'($urandom_range(0, 255));
    cc = 1'($urandom_range(0, 1));
    cs = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      bus8.out_ready = !(cyc >= 4 && cyc <= 6);
      bus8.in_valid  = (sent < 10);
      bus8.a         = ca;
      bus8.b         = cb;
      bus8.cin       = cc;
      bus8.sub       = cs;
      #1;
      if (!bus8.out_ready) begin
        check("stall_rdy", bus8.in_ready, 1'b0);
        check("stall_vld", bus8.out_valid, 1'b1);
        if (cyc == 4) snap = {bus8.zero, bus8.ovf, bus8.cout, 24'd0, bus8.sum};
        else check("stall_hold", {bus8.zero, bus8.ovf, bus8.cout, 24'd0, bus8.sum}, snap);
      end
      if (bus8.out_valid && bus8.out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_spurious", bus8.out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("bp_res", {bus8.zero, bus8.ovf, bus8.cout, 24'd0, bus8.sum}, e);
          got++;
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        exp_q.push_back(model(8, {24'd0, ca}, {24'd0, cb}, cc, cs));
        sent++;
        ca = 8'($urandom_range(0, 255));
        cb = 8'($urandom_range(0, 255));
        cc = 1'($urandom_range(0, 1));
        cs = 1'($urandom_range(0, 1));
      end
      tick;
    end
    check("bp_count", got, 10);
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    tick;
    tick;
    tick;

    // Reset with two operations in flight.
    bus8.in_valid = 1'b1;
    bus8.sub      = 1'b0;
    bus8.a        = 8'h11;
    bus8.b        = 8'h22;
    bus8.cin      = 1'b0;
    #1;
    check("mid_rdy1", bus8.in_ready, 1'b1);
    tick;
    bus8.a = 8'h33;
    bus8.b = 8'h44;
    #1;
    check("mid_rdy2", bus8.in_ready, 1'b1);
    tick;
    bus8.in_valid = 1'b0;
    rst_n         = 1'b0;
    tick;
    check("mid_rst_vld", bus8.out_valid, 1'b0);
    check("mid_rst_sum", bus8.sum, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("mid_no_old", bus8.out_valid, 1'b0);
    end

    // 32-bit, 4-stage: latency and back-to-back throughput.
    bus32.in_valid = 1'b1;
    bus32.sub      = 1'b0;
    bus32.a        = 32'hFFFF_FFFF;
    bus32.b        = 32'h0000_0000;
    bus32.cin      = 1'b1;
    #1;
    check("w32_rdy", bus32.in_ready, 1'b1);
    tick;
    bus32.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("w32_early", bus32.out_valid, 1'b0);
      tick;
    end
    check("w32_vld",  bus32.out_valid, 1'b1);
    check("w32_sum",  bus32.sum, 32'h0000_0000);
    check("w32_cout", bus32.cout, 1'b1);
    check("w32_zero", bus32.zero, 1'b1);
    check("w32_ovf",  bus32.ovf, 1'b0);

    va[0] = 32'h1234_5678; vb[0] = 32'h1111_1111; vc[0] = 1'b0; vs[0] = 1'b0;
    va[1] = 32'h0000_0000; vb[1] = 32'h0000_0001; vc[1] = 1'b0; vs[1] = 1'b1;
    va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0000; vc[2] = 1'b1; vs[2] = 1'b0;
    va[3] = 32'hDEAD_BEEF; vb[3] = 32'hDEAD_BEEF; vc[3] = 1'b0; vs[3] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus32.in_valid = (c < 4);
      if (c < 4) begin
        bus32.a   = va[c];
        bus32.b   = vb[c];
        bus32.cin = vc[c];
        bus32.sub = vs[c];
      end
      #1;
      if (c >= 4 && c < 8) begin
        e = model(32, va[c-4], vb[c-4], vc[c-4], vs[c-4]);
        check("b2b_vld", bus32.out_valid, 1'b1);
        check("b2b_res", {bus32.zero, bus32.ovf, bus32.cout, bus32.sum}, e);
      end else if (c == 8) begin
        check("b2b_end", bus32.out_valid, 1'b0);
      end
      tick;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
